axi4_wr_tlp_chunker: RTL and testbench

- Parametrised successor of the AXI4 write decoder. Accepts one AXI4 write burst at a time (AW + W), splits it into MemWr payload chunks for the TLP packetiser, and returns an AXI4 B response.
- Chunk size is bounded by CHUNK_MAX_BEATS and by 4 KB address boundaries.
- Adds byte enables, burst-type/size checking, malformed-wlast detection and write-response generation.

---
 rtl/axi4_wr_tlp_chunker.sv | 191 +++++++++++++++++++
 tb/tb_axi4_wr_tlp_chunker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_tlp_chunker.sv
// AXI4 write burst to MemWr chunk splitter with B response.
// Ports: s_axi_aw_*/s_axi_w_*/s_axi_b_* AXI4 write slave; out_* chunk stream.
module axi4_wr_tlp_chunker #(
  parameter int          ID_WIDTH        = 4,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 256,
  parameter int          CHUNK_MAX_BEATS = 4,
  parameter logic [15:0] DEVICE_BDF      = 16'h0200
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_axi_aw_avalid,
  output logic                                  s_axi_aw_aready,
  input  logic [ID_WIDTH-1:0]                   s_axi_aw_aid,
  input  logic [ADDR_WIDTH-1:0]                 s_axi_aw_aaddr,
  input  logic [7:0]                            s_axi_aw_alen,
  input  logic [2:0]                            s_axi_aw_asize,
  input  logic [1:0]                            s_axi_aw_aburst,
  input  logic                                  s_axi_w_wvalid,
  output logic                                  s_axi_w_wready,
  input  logic [DATA_WIDTH-1:0]                 s_axi_w_wdata,
  input  logic [DATA_WIDTH/8-1:0]               s_axi_w_wstrb,
  input  logic                                  s_axi_w_wlast,
  output logic                                  s_axi_b_bvalid,
  input  logic                                  s_axi_b_bready,
  output logic [ID_WIDTH-1:0]                   s_axi_b_bid,
  output logic [1:0]                            s_axi_b_bresp,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ADDR_WIDTH-1:0]                 out_addr,
  output logic [9:0]                            out_length,
  output logic [3:0]                            out_first_be,
  output logic [3:0]                            out_last_be,
  output logic [15:0]                           out_bdf,
  output logic [ID_WIDTH-1:0]                   out_tag,
  output logic                                  out_is_memwrite,
  output logic                                  out_last_chunk,
  output logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] out_wdata
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int OFS = $clog2(BPB);
  localparam int DWB = DATA_WIDTH / 32;
  localparam int CW  = $clog2(CHUNK_MAX_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE, COLLECT, EMIT, DRAIN, RESP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [8:0]            beats_left;
  logic [CW-1:0]         chunk_count;
  logic                  err;
  logic                  ended;
  logic [ID_WIDTH-1:0]   tag;
  logic                  beat_fire;
  logic                  is_final;
  logic                  bad_last;
  logic                  close;
  logic [9:0]            len_next;
  logic                  unused;

  assign out_bdf         = DEVICE_BDF;
  assign out_is_memwrite = 1'b1;
  assign out_tag         = tag;
  assign s_axi_b_bid     = tag;

  assign nxt_addr  = cur_addr + ADDR_WIDTH'(BPB);
  assign beat_fire = s_axi_w_wvalid && s_axi_w_wready;
  assign is_final  = (beats_left == 9'd1) || s_axi_w_wlast;
  assign bad_last  = (s_axi_w_wlast && (beats_left > 9'd1))
                  || ((beats_left == 9'd1) && !s_axi_w_wlast);
  // next beat would start a new 4 KB page
  assign close     = (chunk_count == CW'(CHUNK_MAX_BEATS - 1))
                  || is_final
                  || (nxt_addr[11:0] == 12'd0);
  assign len_next  = (10'(chunk_count) + 10'd1) * 10'(DWB);

  assign unused = ^{s_axi_w_wstrb, s_axi_aw_aaddr[OFS-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      s_axi_aw_aready <= 1'b0;
      s_axi_w_wready  <= 1'b0;
      s_axi_b_bvalid  <= 1'b0;
      s_axi_b_bresp   <= 2'b00;
      out_valid       <= 1'b0;
      out_addr        <= '0;
      out_length      <= '0;
      out_first_be    <= '0;
      out_last_be     <= '0;
      out_last_chunk  <= 1'b0;
      out_wdata       <= '0;
      cur_addr        <= '0;
      beats_left      <= '0;
      chunk_count     <= '0;
      err             <= 1'b0;
      ended           <= 1'b0;
      tag             <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_axi_aw_avalid && s_axi_aw_aready) begin
            s_axi_aw_aready <= 1'b0;
            s_axi_w_wready  <= 1'b1;
            tag             <= s_axi_aw_aid;
            cur_addr        <= {s_axi_aw_aaddr[ADDR_WIDTH-1:OFS],
                                {OFS{1'b0}}};
            beats_left      <= 9'(s_axi_aw_alen) + 9'd1;
            chunk_count     <= '0;
            ended           <= 1'b0;
            if (s_axi_aw_aburst == 2'b01 &&
                s_axi_aw_asize == 3'(OFS)) begin
              err   <= 1'b0;
              state <= COLLECT;
            end else begin
              err   <= 1'b1;
              state <= DRAIN;
            end
          end else begin
            s_axi_aw_aready <= 1'b1;
          end
        end
        COLLECT: begin
          if (beat_fire) begin
            for (int k = 0; k < CHUNK_MAX_BEATS; k++) begin
              if (chunk_count == CW'(k))
                out_wdata[k*DATA_WIDTH +: DATA_WIDTH] <= s_axi_w_wdata;
            end
            if (chunk_count == '0) begin
              out_addr     <= cur_addr;
              out_first_be <= s_axi_w_wstrb[3:0];
            end
            chunk_count <= chunk_count + 1'b1;
            beats_left  <= beats_left - 9'd1;
            cur_addr    <= nxt_addr;
            if (bad_last)
              err <= 1'b1;
            if (close) begin
              s_axi_w_wready <= 1'b0;
              out_valid      <= 1'b1;
              out_length     <= len_next;
              out_last_be    <= s_axi_w_wstrb[BPB-1 -: 4];
              out_last_chunk <= is_final;
              ended          <= is_final;
              state          <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_wdata   <= '0;
            chunk_count <= '0;
            if (ended) begin
              s_axi_b_bvalid <= 1'b1;
              s_axi_b_bresp  <= err ? 2'b10 : 2'b00;
              state          <= RESP;
            end else begin
              s_axi_w_wready <= 1'b1;
              state          <= COLLECT;
            end
          end
        end
        DRAIN: begin
          if (beat_fire) begin
            beats_left <= beats_left - 9'd1;
            if (s_axi_w_wlast || beats_left <= 9'd1) begin
              s_axi_w_wready <= 1'b0;
              s_axi_b_bvalid <= 1'b1;
              s_axi_b_bresp  <= err ? 2'b10 : 2'b00;
              state          <= RESP;
            end
          end
        end
        RESP: begin
          if (s_axi_b_bready) begin
            s_axi_b_bvalid  <= 1'b0;
            s_axi_aw_aready <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_wr_tlp_chunker.sv
// Bench for axi4_wr_tlp_chunker: directed and random bursts vs chunk model.
// Drives and samples on the falling edge; DUT outputs are all registered.
module tb_axi4_wr_tlp_chunker;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 256;
  localparam int MB  = 4;
  localparam int BPB = DW / 8;
  localparam int WB  = DW * MB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           s_axi_aw_avalid = 1'b0;
  logic           s_axi_aw_aready;
  logic [IDW-1:0] s_axi_aw_aid = '0;
  logic [AW-1:0]  s_axi_aw_aaddr = '0;
  logic [7:0]     s_axi_aw_alen = '0;
  logic [2:0]     s_axi_aw_asize = '0;
  logic [1:0]     s_axi_aw_aburst = '0;
  logic           s_axi_w_wvalid = 1'b0;
  logic           s_axi_w_wready;
  logic [DW-1:0]  s_axi_w_wdata = '0;
  logic [BPB-1:0] s_axi_w_wstrb = '0;
  logic           s_axi_w_wlast = 1'b0;
  logic           s_axi_b_bvalid;
  logic           s_axi_b_bready = 1'b0;
  logic [IDW-1:0] s_axi_b_bid;
  logic [1:0]     s_axi_b_bresp;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [AW-1:0]  out_addr;
  logic [9:0]     out_length;
  logic [3:0]     out_first_be;
  logic [3:0]     out_last_be;
  logic [15:0]    out_bdf;
  logic [IDW-1:0] out_tag;
  logic           out_is_memwrite;
  logic           out_last_chunk;
  logic [WB-1:0]  out_wdata;

  axi4_wr_tlp_chunker #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CHUNK_MAX_BEATS(MB), .DEVICE_BDF(16'h0200)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_aw_avalid(s_axi_aw_avalid), .s_axi_aw_aready(s_axi_aw_aready),
    .s_axi_aw_aid(s_axi_aw_aid), .s_axi_aw_aaddr(s_axi_aw_aaddr),
    .s_axi_aw_alen(s_axi_aw_alen), .s_axi_aw_asize(s_axi_aw_asize),
    .s_axi_aw_aburst(s_axi_aw_aburst),
    .s_axi_w_wvalid(s_axi_w_wvalid), .s_axi_w_wready(s_axi_w_wready),
    .s_axi_w_wdata(s_axi_w_wdata), .s_axi_w_wstrb(s_axi_w_wstrb),
    .s_axi_w_wlast(s_axi_w_wlast),
    .s_axi_b_bvalid(s_axi_b_bvalid), .s_axi_b_bready(s_axi_b_bready),
    .s_axi_b_bid(s_axi_b_bid), .s_axi_b_bresp(s_axi_b_bresp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_length(out_length),
    .out_first_be(out_first_be), .out_last_be(out_last_be),
    .out_bdf(out_bdf), .out_tag(out_tag),
    .out_is_memwrite(out_is_memwrite), .out_last_chunk(out_last_chunk),
    .out_wdata(out_wdata)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // mode 0: sink always ready, 1: random ready/bready,
  // 2: hold out_ready low for 5 cycles on the first chunk
  task automatic run_burst(input logic [AW-1:0] addr, input int len_m1,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int wl_idx, input logic [BPB-1:0] strb0,
                           input int mode);
    logic [DW-1:0]  bd[256];
    logic [BPB-1:0] bs[256];
    logic [AW-1:0]  e_addr[256];
    int             e_len[256];
    logic [3:0]     e_fbe[256];
    logic [3:0]     e_lbe[256];
    bit             e_last[256];
    logic [WB-1:0]  e_data[256];
    logic [AW-1:0]  base;
    logic [AW-1:0]  a;
    logic [IDW-1:0] id;
    int n_send, n_acc, nq, cnt, beat, ci, stall;
    bit good, err, aw_done, b_done;

    id     = IDW'($urandom);
    n_send = (wl_idx <= len_m1) ? wl_idx + 1 : len_m1 + 1;
    good   = (burst == 2'b01) && (size == 3'd5);
    err    = !good || (wl_idx != len_m1);
    n_acc  = good ? n_send : 0;
    for (int b = 0; b < n_send; b++) begin
      for (int w = 0; w < DW / 32; w++) bd[b][w*32 +: 32] = $urandom;
      bs[b] = $urandom;
    end
    bs[0] = strb0;

    // Reference chunk list: group beats, max MB per chunk,
    // never crossing a 4 KB page.
    base = {addr[AW-1:5], 5'b0};
    nq = 0;
    cnt = 0;
    for (int b = 0; b < n_acc; b++) begin
      a = base + AW'(b * BPB);
      if (cnt == 0) begin
        e_addr[nq] = a;
        e_fbe[nq]  = bs[b][3:0];
        e_data[nq] = '0;
      end
      e_data[nq][cnt*DW +: DW] = bd[b];
      cnt++;
      if (cnt == MB || b == n_acc - 1 || (a % 4096) == 4096 - BPB) begin
        e_len[nq]  = cnt * (DW / 32);
        e_lbe[nq]  = bs[b][BPB-1 -: 4];
        e_last[nq] = (b == n_acc - 1);
        nq++;
        cnt = 0;
      end
    end

    aw_done = 0;
    b_done  = 0;
    beat    = 0;
    ci      = 0;
    stall   = 0;
    for (int cyc = 0; cyc < 2000 && !b_done; cyc++) begin
      @(negedge clk);
      s_axi_aw_avalid = !aw_done;
      s_axi_aw_aid    = id;
      s_axi_aw_aaddr  = addr;
      s_axi_aw_alen   = 8'(len_m1);
      s_axi_aw_asize  = size;
      s_axi_aw_aburst = burst;
      s_axi_w_wvalid  = aw_done && (beat < n_send);
      s_axi_w_wdata   = (beat < n_send) ? bd[beat] : '0;
      s_axi_w_wstrb   = (beat < n_send) ? bs[beat] : '0;
      s_axi_w_wlast   = (beat < n_send) && (beat == wl_idx);
      case (mode)
        1:       out_ready = 1'($urandom % 2);
        2:       out_ready = (ci > 0) || (stall >= 5);
        default: out_ready = 1'b1;
      endcase
      s_axi_b_bready = (mode == 1) ? 1'($urandom % 2) : 1'b1;

      if (s_axi_aw_avalid && s_axi_aw_aready) aw_done = 1;
      if (s_axi_w_wvalid && s_axi_w_wready) beat++;

      if (out_valid) begin
        if (ci < nq) begin
          chk("chunk_addr", out_addr, e_addr[ci]);
          chk("chunk_len", out_length, e_len[ci]);
          chk("first_be", out_first_be, e_fbe[ci]);
          chk("last_be", out_last_be, e_lbe[ci]);
          chk("last_chunk", out_last_chunk, e_last[ci]);
          chk("tag", out_tag, id);
          chk("bdf", out_bdf, 16'h0200);
          chk("is_memwrite", out_is_memwrite, 1'b1);
          chk("wready_in_emit", s_axi_w_wready, 1'b0);
          for (int s = 0; s < MB; s++)
            chk("chunk_data", out_wdata[s*DW +: DW], e_data[ci][s*DW +: DW]);
        end else begin
          chk("spurious_chunk", out_valid, 1'b0);
        end
        if (out_ready) ci++;
        else stall++;
      end

      if (s_axi_b_bvalid && s_axi_b_bready) begin
        chk("bid", s_axi_b_bid, id);
        chk("bresp", s_axi_b_bresp, err ? 2'b10 : 2'b00);
        chk("chunks_seen", ci, nq);
        chk("beats_taken", beat, n_send);
        chk("wready_in_resp", s_axi_w_wready, 1'b0);
        b_done = 1;
      end
    end
    chk("b_timeout", 32'(b_done), 1);
  endtask

  initial begin
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_aready", s_axi_aw_aready, 1'b0);
    chk("rst_wready", s_axi_w_wready, 1'b0);
    chk("rst_bvalid", s_axi_b_bvalid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bresp", s_axi_b_bresp, 2'b00);
    chk("rst_last_chunk", out_last_chunk, 1'b0);
    rst_n = 1'b1;
    chk("aready_before_clk", s_axi_aw_aready, 1'b0);
    @(negedge clk);
    chk("aready_after_clk", s_axi_aw_aready, 1'b1);

    run_burst(32'h0000_1000, 7, 3'd5, 2'b01, 7, '1, 0);
    run_burst(32'h0000_0FC0, 3, 3'd5, 2'b01, 3, '1, 0);
    run_burst(32'h0000_2000, 2, 3'd5, 2'b01, 2, 32'hFFFF_FFF0, 0);
    run_burst(32'h0000_3000, 3, 3'd5, 2'b01, 1, '1, 0);
    run_burst(32'h0000_4000, 3, 3'd5, 2'b10, 3, '1, 0);
    run_burst(32'h0000_5000, 5, 3'd5, 2'b01, 5, '1, 2);
    run_burst(32'h0000_6000, 2, 3'd5, 2'b01, 99, '1, 0);
    run_burst(32'h0000_7000, 1, 3'd4, 2'b01, 1, '1, 0);
    run_burst(32'hFFFF_FFC0, 3, 3'd5, 2'b01, 3, '1, 0);

    for (int i = 0; i < 25; i++) begin
      int          l;
      int          wl;
      logic [1:0]  bt;
      logic [2:0]  sz;
      logic [AW-1:0] ad;
      l  = $urandom_range(0, 15);
      ad = (32'($urandom_range(0, 15)) << 12) + 32'($urandom_range(0, 4095));
      bt = ($urandom % 8 == 0) ? 2'b10 : 2'b01;
      sz = ($urandom % 8 == 0) ? 3'd3 : 3'd5;
      case ($urandom % 6)
        0:       wl = $urandom_range(0, l);
        1:       wl = 99;
        default: wl = l;
      endcase
      run_burst(ad, l, sz, bt, wl, BPB'($urandom), 1);
    end

    // reset in the middle of a burst
    @(negedge clk);
    s_axi_b_bready  = 1'b0;
    s_axi_aw_avalid = 1'b1;
    s_axi_aw_aid    = 4'd5;
    s_axi_aw_aaddr  = 32'h0000_8000;
    s_axi_aw_alen   = 8'd3;
    s_axi_aw_asize  = 3'd5;
    s_axi_aw_aburst = 2'b01;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (s_axi_aw_aready) seen = 1;
      else @(negedge clk);
    end
    chk("rst_test_aw", 32'(seen), 1);
    @(negedge clk);
    s_axi_aw_avalid = 1'b0;
    s_axi_w_wvalid  = 1'b1;
    s_axi_w_wdata   = {8{32'hA5A5_5A5A}};
    s_axi_w_wstrb   = '1;
    s_axi_w_wlast   = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (s_axi_w_wready) seen = 1;
      else @(negedge clk);
    end
    chk("rst_test_w", 32'(seen), 1);
    @(negedge clk);
    s_axi_w_wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_aready", s_axi_aw_aready, 1'b0);
    chk("mid_rst_wready", s_axi_w_wready, 1'b0);
    chk("mid_rst_bvalid", s_axi_b_bvalid, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_wdata0", out_wdata[DW-1:0], '0);
    chk("mid_rst_addr", out_addr, '0);
    chk("mid_rst_tag", out_tag, '0);
    chk("mid_rst_bid", s_axi_b_bid, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_aready_0", s_axi_aw_aready, 1'b0);
    @(negedge clk);
    chk("rel_aready_1", s_axi_aw_aready, 1'b1);
    chk("rel_bvalid", s_axi_b_bvalid, 1'b0);
    run_burst(32'h0000_9020, 4, 3'd5, 2'b01, 4, '1, 0);

    @(negedge clk);
    s_axi_aw_avalid = 1'b0;
    s_axi_w_wvalid  = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
